cache_way_array: RTL and testbench

- Parametrised N-way set-associative line store for the LC-3b cache datapath; successor to the single-way line array.
- Holds per-way data, tag, valid and dirty plus per-set tree pseudo-LRU.
- Provides combinational hit detection, victim selection and byte-masked writes.
- Adds a multi-cycle invalidate-all sweep controlled by a small FSM; sits between the cache control FSM and the memory interface.

---
 rtl/lc3b_types.sv | 20 ++
 rtl/plru_tree.sv | 44 ++++
 rtl/cache_way_array.sv | 159 +++++++++++++++
 tb/tb_cache_way_array.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, extended with the set-associative cache line store
// geometry, its storage typedefs and the invalidate-sweep state encoding.
package lc3b_types;

    localparam int C_WAYS       = 2;
    localparam int C_SETS       = 8;
    localparam int C_LINE_WIDTH = 128;
    localparam int C_TAG_WIDTH  = 9;

    typedef logic [$clog2(C_WAYS)-1:0]   lc3b_c_way;
    typedef logic [C_TAG_WIDTH-1:0]      lc3b_c_tag;
    typedef logic [C_LINE_WIDTH-1:0]     lc3b_c_line;
    typedef logic [C_LINE_WIDTH/8-1:0]   lc3b_c_mask;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } lc3b_c_sweep_state;

endpackage

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU: walks the node bits of one set to produce the
// replacement way, and the node bits after touching a given way.
module plru_tree #(
    parameter int WAYS  = 2,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  node_bits,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAYS-2:0]  new_bits,
    output logic [WAY_W-1:0] victim_way
);

    // Heap-ordered nodes: children of node n are 2n+1 (lower half) and 2n+2 (upper half).
    localparam int NODE_W = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

    always_comb begin : touch_walk
        logic [NODE_W-1:0] node;
        logic              dir;
        // NOTE: every variable assigned in always_comb gets a value up front so no
        // path can leave it unassigned and infer a latch.
        new_bits = node_bits;
        node     = '0;
        dir      = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            dir            = touch_way[WAY_W-1-l];
            new_bits[node] = ~dir;
            node           = NODE_W'((int'(node) << 1) + 1 + int'(dir));
        end
    end

    always_comb begin : victim_walk
        logic [NODE_W-1:0] node;
        logic              dir;
        victim_way = '0;
        node       = '0;
        dir        = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            dir                   = node_bits[node];
            victim_way[WAY_W-1-l] = dir;
            node                  = NODE_W'((int'(node) << 1) + 1 + int'(dir));
        end
    end

endmodule

// File: rtl/cache_way_array.sv
// N-way set-associative line store: per-way data/tag/valid/dirty, per-set tree
// pLRU, combinational lookup and victim choice, plus an invalidate-all sweep.
module cache_way_array
    import lc3b_types::*;
#(
    parameter int WAYS        = C_WAYS,
    parameter int SETS        = C_SETS,
    parameter int LINE_WIDTH  = C_LINE_WIDTH,
    parameter int TAG_WIDTH   = C_TAG_WIDTH,
    parameter int INDEX_WIDTH = $clog2(SETS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [INDEX_WIDTH-1:0]    index,
    input  logic [TAG_WIDTH-1:0]      tag_in,
    output logic                      hit,
    output logic [$clog2(WAYS)-1:0]   hit_way,
    output logic [LINE_WIDTH-1:0]     rdata,
    output logic [$clog2(WAYS)-1:0]   victim_way,
    output logic                      victim_valid,
    output logic                      victim_dirty,
    output logic [TAG_WIDTH-1:0]      victim_tag,
    input  logic                      access,
    input  logic                      write,
    input  logic [$clog2(WAYS)-1:0]   write_way,
    input  logic [LINE_WIDTH/8-1:0]   wmask,
    input  logic [LINE_WIDTH-1:0]     wdata,
    input  logic                      fill,
    input  logic                      set_dirty,
    input  logic                      inv_start,
    output logic                      busy,
    output logic                      inv_done
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int BYTES = LINE_WIDTH / 8;

    logic [LINE_WIDTH-1:0] data_mem [WAYS][SETS];
    logic [TAG_WIDTH-1:0]  tag_mem  [WAYS][SETS];
    logic [WAYS-1:0]       valid_q  [SETS];
    logic [WAYS-1:0]       dirty_q  [SETS];
    logic [WAYS-2:0]       lru_q    [SETS];

    lc3b_c_sweep_state      state_q, state_d;
    logic [INDEX_WIDTH-1:0] sweep_cnt;
    logic                   last_set;

    logic [WAYS-1:0]  match, set_valid;
    logic             any_invalid;
    logic [WAY_W-1:0] match_way, invalid_way, plru_victim, touch_way;
    logic [WAYS-2:0]  lru_touched;
    logic [WAYS-2:0]  unused_victim_bits;
    logic [WAY_W-1:0] unused_touch_victim;
    logic             wr_en, acc_en;

    assign busy     = (state_q == SWEEP);
    assign last_set = (sweep_cnt == INDEX_WIDTH'(SETS - 1));
    assign inv_done = busy && last_set;
    assign wr_en    = write && !busy;
    assign acc_en   = access && hit && !write;

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        set_valid   = valid_q[index];
        match       = '0;
        match_way   = '0;
        invalid_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            match[w] = set_valid[w] && (tag_mem[w][index] == tag_in);
            if (match[w])
                match_way = WAY_W'(w);
            if (!set_valid[w])
                invalid_way = WAY_W'(w);
        end
    end

    assign any_invalid  = ~&set_valid;
    assign hit          = !busy && (|match);
    assign hit_way      = match_way;
    assign victim_way   = any_invalid ? invalid_way : plru_victim;
    assign victim_valid = set_valid[victim_way];
    assign victim_dirty = dirty_q[index][victim_way];
    assign victim_tag   = tag_mem[victim_way][index];
    assign rdata        = hit ? data_mem[match_way][index] : data_mem[victim_way][index];

    assign touch_way = wr_en ? write_way : match_way;

    plru_tree #(.WAYS(WAYS), .WAY_W(WAY_W)) u_touch (
        .node_bits  (lru_q[index]),
        .touch_way  (touch_way),
        .new_bits   (lru_touched),
        .victim_way (unused_touch_victim)
    );

    plru_tree #(.WAYS(WAYS), .WAY_W(WAY_W)) u_victim (
        .node_bits  (lru_q[index]),
        .touch_way  (touch_way),
        .new_bits   (unused_victim_bits),
        .victim_way (plru_victim)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inv_start) state_d = SWEEP;
            SWEEP:   if (last_set)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sweep_cnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                lru_q[s]   <= '0;
            end
        end else begin
            state_q <= state_d;
            if (busy) begin
                valid_q[sweep_cnt] <= '0;
                dirty_q[sweep_cnt] <= '0;
                lru_q[sweep_cnt]   <= '0;
                sweep_cnt          <= last_set ? '0 : sweep_cnt + 1'b1;
            end else begin
                sweep_cnt <= '0;
                if (wr_en) begin
                    if (fill) begin
                        valid_q[index][write_way] <= 1'b1;
                        dirty_q[index][write_way] <= set_dirty;
                    end else if (set_dirty) begin
                        dirty_q[index][write_way] <= 1'b1;
                    end
                    lru_q[index] <= lru_touched;
                end else if (acc_en) begin
                    lru_q[index] <= lru_touched;
                end
            end
        end
    end

    // NOTE: line and tag storage carry no reset; valid bits gate their use, and
    // leaving them unreset lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wmask[b])
                    data_mem[write_way][index][b*8 +: 8] <= wdata[b*8 +: 8];
            end
            if (fill)
                tag_mem[write_way][index] <= tag_in;
        end
    end

endmodule

// File: tb/tb_cache_way_array.sv
// Directed bench for cache_way_array (2 ways, 8 sets): expectations are queued
// as stimulus is applied and popped against the DUT outputs once they settle.
module tb_cache_way_array;
    import lc3b_types::*;

    localparam int WAYS = 2;
    localparam int SETS = 8;
    localparam int LW   = 128;
    localparam int TW   = 9;
    localparam int IW   = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [IW-1:0] index;
    logic [TW-1:0] tag_in;
    logic          hit;
    lc3b_c_way     hit_way, victim_way, write_way;
    logic [LW-1:0] rdata, wdata;
    logic          victim_valid, victim_dirty;
    logic [TW-1:0] victim_tag;
    logic          access, write, fill, set_dirty, inv_start, busy, inv_done;
    lc3b_c_mask    wmask;

    always #5 clk = ~clk;

    cache_way_array #(
        .WAYS(WAYS), .SETS(SETS), .LINE_WIDTH(LW), .TAG_WIDTH(TW), .INDEX_WIDTH(IW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .index(index), .tag_in(tag_in),
        .hit(hit), .hit_way(hit_way), .rdata(rdata), .victim_way(victim_way),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .access(access), .write(write), .write_way(write_way), .wmask(wmask),
        .wdata(wdata), .fill(fill), .set_dirty(set_dirty), .inv_start(inv_start),
        .busy(busy), .inv_done(inv_done)
    );

    typedef struct {
        string        name;
        logic [127:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        vectors     = 0;
    int        miscompares = 0;

    localparam logic [LW-1:0] LINE_AA  = {16{8'hAA}};
    localparam logic [LW-1:0] LINE_55  = {16{8'h55}};
    localparam logic [LW-1:0] LINE_MIX = {{15{8'hAA}}, 8'h5A};

    task automatic expect_v(input string name, input logic [127:0] exp);
        sb_q.push_back('{name, exp});
    endtask

    task automatic check(input logic [127:0] obs);
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_underflow: observed %h expected a queued entry", obs);
        end else begin
            e = sb_q.pop_front();
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
        index  = idx;
        tag_in = tag;
        #1;
    endtask

    task automatic do_write(input lc3b_c_way way, input logic [IW-1:0] idx,
                            input logic [TW-1:0] tag, input lc3b_c_mask mask,
                            input logic [LW-1:0] data, input logic f, input logic sd);
        write     = 1'b1;
        write_way = way;
        index     = idx;
        tag_in    = tag;
        wmask     = mask;
        wdata     = data;
        fill      = f;
        set_dirty = sd;
        tick();
        write     = 1'b0;
        fill      = 1'b0;
        set_dirty = 1'b0;
    endtask

    task automatic do_access(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
        index  = idx;
        tag_in = tag;
        access = 1'b1;
        tick();
        access = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; index = '0; tag_in = '0; access = 1'b0; write = 1'b0;
        write_way = '0; wmask = '0; wdata = '0; fill = 1'b0; set_dirty = 1'b0;
        inv_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Reset state across every set
        for (int i = 0; i < SETS; i++) begin
            probe(IW'(i), 9'h05);
            expect_v($sformatf("rst_hit_%0d", i), 0);
            expect_v($sformatf("rst_victim_way_%0d", i), 0);
            expect_v($sformatf("rst_victim_valid_%0d", i), 0);
            expect_v($sformatf("rst_victim_dirty_%0d", i), 0);
            expect_v($sformatf("rst_busy_%0d", i), 0);
            expect_v($sformatf("rst_inv_done_%0d", i), 0);
            check(hit); check(victim_way); check(victim_valid);
            check(victim_dirty); check(busy); check(inv_done);
        end

        // Fill way 0 of set 3
        do_write(1'b0, 3'd3, 9'h05, 16'hFFFF, LINE_AA, 1'b1, 1'b0);
        probe(3'd3, 9'h05);
        expect_v("fill_hit", 1); expect_v("fill_hit_way", 0); expect_v("fill_rdata", LINE_AA);
        check(hit); check(hit_way); check(rdata);
        probe(3'd3, 9'h06);
        expect_v("miss_hit", 0); expect_v("miss_victim_way", 1); expect_v("miss_victim_valid", 0);
        check(hit); check(victim_way); check(victim_valid);

        // Fill way 1, then pLRU ordering
        do_write(1'b1, 3'd3, 9'h06, 16'hFFFF, LINE_55, 1'b1, 1'b0);
        probe(3'd3, 9'h06);
        expect_v("way1_hit_way", 1); expect_v("way1_rdata", LINE_55);
        check(hit_way); check(rdata);
        probe(3'd3, 9'h07);
        expect_v("full_victim_way", 0); expect_v("full_victim_valid", 1); expect_v("full_rdata", LINE_AA);
        check(victim_way); check(victim_valid); check(rdata);
        do_access(3'd3, 9'h05);
        probe(3'd3, 9'h07);
        expect_v("lru_victim_way", 1); expect_v("lru_victim_tag", 9'h06);
        check(victim_way); check(victim_tag);

        // Byte-masked write: old line visible before the edge, merged line after
        write = 1'b1; write_way = 1'b0; wmask = 16'h0001; wdata = 128'h5A;
        fill = 1'b0; set_dirty = 1'b1;
        probe(3'd3, 9'h05);
        expect_v("rdw_old_rdata", LINE_AA);
        check(rdata);
        tick();
        write = 1'b0; set_dirty = 1'b0;
        probe(3'd3, 9'h05);
        expect_v("mask_rdata", LINE_MIX);
        check(rdata);
        probe(3'd3, 9'h07);
        expect_v("mask_victim_way", 1); expect_v("mask_victim_dirty", 0);
        check(victim_way); check(victim_dirty);
        do_access(3'd3, 9'h06);
        probe(3'd3, 9'h07);
        expect_v("dirty_victim_way", 0); expect_v("dirty_victim_dirty", 1);
        expect_v("dirty_victim_tag", 9'h05);
        check(victim_way); check(victim_dirty); check(victim_tag);

        // Invalidate-all sweep; a write to set 5 on the final busy cycle is dropped
        inv_start = 1'b1;
        tick();
        inv_start = 1'b0;
        for (int c = 1; c <= SETS; c++) begin
            if (c == SETS) begin
                write = 1'b1; write_way = 1'b1; wmask = 16'hFFFF; fill = 1'b1;
                probe(3'd5, 9'h0A);
            end else begin
                probe(3'd3, 9'h05);
            end
            expect_v($sformatf("sweep_busy_%0d", c), 1);
            expect_v($sformatf("sweep_inv_done_%0d", c), (c == SETS) ? 1 : 0);
            expect_v($sformatf("sweep_hit_%0d", c), 0);
            check(busy); check(inv_done); check(hit);
            tick();
        end
        write = 1'b0; fill = 1'b0;
        probe(3'd3, 9'h05);
        expect_v("post_busy", 0); expect_v("post_inv_done", 0);
        expect_v("post_hit", 0); expect_v("post_victim_valid", 0);
        check(busy); check(inv_done); check(hit); check(victim_valid);
        probe(3'd5, 9'h0A);
        expect_v("dropped_write_hit", 0); expect_v("dropped_write_valid", 0);
        check(hit); check(victim_valid);

        // Reset in the middle of a sweep
        do_write(1'b0, 3'd6, 9'h05, 16'hFFFF, LINE_55, 1'b1, 1'b1);
        probe(3'd6, 9'h05);
        expect_v("pre_midrst_hit", 1);
        check(hit);
        inv_start = 1'b1;
        tick();
        inv_start = 1'b0;
        repeat (3) tick();
        expect_v("midsweep_busy", 1);
        check(busy);
        reset_n = 1'b0;
        #1;
        expect_v("midrst_busy", 0); expect_v("midrst_inv_done", 0);
        check(busy); check(inv_done);
        #2 reset_n = 1'b1;
        for (int i = 0; i < SETS; i++) begin
            probe(IW'(i), 9'h05);
            expect_v($sformatf("midrst_hit_%0d", i), 0);
            expect_v($sformatf("midrst_victim_valid_%0d", i), 0);
            check(hit); check(victim_valid);
        end
        for (int c = 0; c < SETS; c++) begin
            tick();
            expect_v($sformatf("midrst_idle_busy_%0d", c), 0);
            expect_v($sformatf("midrst_idle_done_%0d", c), 0);
            check(busy); check(inv_done);
        end

        if (sb_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover: observed %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
